// File: rtl/top_mul_sched_pkg.sv
// Shared widths and the stage-1 payload type for the shared wide multiplier.
package top_mul_sched_pkg;

   localparam int unsigned AW       = 28;
   localparam int unsigned BW       = 92;
   localparam int unsigned PW       = 120;
   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned MAX_IDW  = $clog2(MAX_NREQ);

   // Operands and requester index captured at the grant.
   typedef struct packed {
      logic [AW-1:0]      a;
      logic [BW-1:0]      b;
      logic [MAX_IDW-1:0] id;
   } s1_t;

endpackage

// File: rtl/top_mul_rr_arb.sv
// Combinational round-robin arbiter: the first valid index at or after ptr wins.
module top_mul_rr_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int unsigned      cand;
   logic [IDW-1:0]   cidx;

   // Scan from ptr with wraparound; the grant is suppressed when not enabled.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      cidx = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = (32'(ptr) + off) % NREQ;
         cidx = IDW'(cand);
         if (!any && valid[cidx]) begin
            any = 1'b1;
            idx = cidx;
         end
      end
      if (enable && any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/top_mul_share_sched.sv
// One combinational AWxBW multiplier shared by NREQ requesters through a
// round-robin arbiter and a two-stage valid/ready pipeline.
module top_mul_share_sched
   import top_mul_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*AW-1:0] req_a,
   input  logic [NREQ*BW-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [PW-1:0]     rsp_prod,
   output logic [31:0]       grant_cnt
);

   logic            s1_v;
   s1_t             s1_q;
   logic            s2_v;
   logic [PW-1:0]   s2_prod;
   logic [IDW-1:0]  s2_id;
   logic [IDW-1:0]  rr_ptr;
   logic [31:0]     cnt;

   logic            adv1;
   logic            adv2;
   logic            hs;
   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic [AW-1:0]   sel_a;
   logic [BW-1:0]   sel_b;
   logic [PW-1:0]   mul_prod;

   assign adv2 = s1_v & (~s2_v | rsp_ready);
   assign adv1 = ~s1_v | adv2;

   // Reset is folded into the enable so req_ready reads 0 while held in reset.
   top_mul_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .valid  (req_valid),
      .ptr    (rr_ptr),
      .enable (adv1 & ap_rst_n),
      .gnt    (arb_gnt),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   assign hs        = |arb_gnt;
   assign req_ready = arb_gnt;

   // Operand mux steered by the one-hot grant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            sel_a = req_a[i*AW +: AW];
            sel_b = req_b[i*BW +: BW];
         end
      end
   end

   assign mul_prod = PW'(s1_q.a) * PW'(s1_q.b);

   // Stage 1: capture the granted operands whenever the stage may advance.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_v <= 1'b0;
         s1_q <= '0;
      end else if (adv1) begin
         s1_v <= hs;
         if (hs) begin
            s1_q.a  <= sel_a;
            s1_q.b  <= sel_b;
            s1_q.id <= MAX_IDW'(arb_idx);
         end
      end
   end

   // Stage 2: register the product; holds while the consumer stalls.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s2_v    <= 1'b0;
         s2_prod <= '0;
         s2_id   <= '0;
      end else if (adv2) begin
         s2_v    <= 1'b1;
         s2_prod <= mul_prod;
         s2_id   <= IDW'(s1_q.id);
      end else if (rsp_ready) begin
         s2_v    <= 1'b0;
      end
   end

   // Round-robin pointer and accepted-request counter move only on a handshake.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rr_ptr <= '0;
         cnt    <= '0;
      end else if (hs) begin
         rr_ptr <= (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
         cnt    <= cnt + 32'd1;
      end
   end

   assign rsp_valid = s2_v;
   assign rsp_id    = s2_id;
   assign rsp_prod  = s2_prod;
   assign grant_cnt = cnt;

endmodule

// File: tb/tb_top_mul_share_sched.sv
// Self-checking bench for top_mul_share_sched: directed scenarios plus a
// randomized phase, all scored against a queue-based reference model.
module tb_top_mul_share_sched;

   localparam int NREQ = 4;
   localparam int AW   = 28;
   localparam int BW   = 92;
   localparam int PW   = 120;
   localparam int IDW  = 2;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n = 1'b1;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*BW-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [PW-1:0]      rsp_prod;
   logic [31:0]        grant_cnt;

   top_mul_share_sched #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_prod  (rsp_prod),
      .grant_cnt (grant_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   // Reference model: in-flight results in acceptance order; age counts the
   // register stages an item has passed (1 after capture, 2 once it can show).
   typedef struct {
      int            id;
      logic [PW-1:0] prod;
      int            age;
   } item_t;

   item_t          q[$];
   int             rsp_log[$];
   logic           pv[NREQ];
   logic [AW-1:0]  pa[NREQ];
   logic [BW-1:0]  pb[NREQ];
   int             mptr;
   logic [31:0]    mcnt;
   int             mode;
   int             checks = 0;
   int             errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic newreq(input int i);
      pv[i] = 1'b1;
      pa[i] = AW'($urandom);
      pb[i] = BW'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 7) == 0) pa[i] = '1;
      if ($urandom_range(0, 7) == 0) pb[i] = '1;
   endtask

   task automatic setreq(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
      pv[i] = 1'b1;
      pa[i] = a;
      pb[i] = b;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]          = pv[i];
         req_a[i*AW +: AW]     = pa[i];
         req_b[i*BW +: BW]     = pb[i];
      end
   endtask

   function automatic int pick();
      for (int off = 0; off < NREQ; off++) begin
         if (pv[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
      end
      return -1;
   endfunction

   // One clock: check outputs against the model, step across the edge, update the model.
   task automatic cycle();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic            exp_rv;
      logic            taken;
      logic [PW-1:0]   ea;
      logic [PW-1:0]   eb;
      item_t           it;
      drive();
      #1;
      g       = pick();
      exp_rdy = '0;
      if (g >= 0 && (q.size() < 2 || rsp_ready)) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      exp_rv = (q.size() > 0) && (q[0].age >= 2);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
         chk("rsp_id", rsp_id, q[0].id);
         chk("rsp_prod", rsp_prod, q[0].prod);
      end
      chk("grant_cnt", grant_cnt, mcnt);
      taken = exp_rv && rsp_ready;
      @(posedge ap_clk);
      if (taken) begin
         rsp_log.push_back(q[0].id);
         void'(q.pop_front());
      end
      foreach (q[k]) q[k].age++;
      if (exp_rdy != '0) begin
         ea      = PW'(pa[g]);
         eb      = PW'(pb[g]);
         it.id   = g;
         it.prod = ea * eb;
         it.age  = 1;
         q.push_back(it);
         mptr = (g + 1) % NREQ;
         mcnt = mcnt + 32'd1;
         case (mode)
            0: pv[g] = 1'b0;
            1: newreq(g);
            default: if ($urandom_range(0, 1) == 1) newreq(g); else pv[g] = 1'b0;
         endcase
      end
      @(negedge ap_clk);
   endtask

   task automatic apply_reset();
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      drive();
      ap_rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_id", rsp_id, '0);
      chk("rst_rsp_prod", rsp_prod, '0);
      chk("rst_grant_cnt", grant_cnt, '0);
      q.delete();
      mptr = 0;
      mcnt = '0;
      mode = 0;
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   initial begin
      int            t3e[6];
      int            t4e[3];
      logic [127:0]  big;
      logic [PW-1:0] held;

      t3e = '{0, 1, 2, 3, 0, 1};
      t4e = '{2, 0, 1};
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
         pb[i] = '0;
      end
      mptr      = 0;
      mcnt      = '0;
      mode      = 0;
      rsp_ready = 1'b1;
      drive();
      @(negedge ap_clk);
      apply_reset();

      // T1: single request, result two register stages later
      setreq(0, 28'd3, 92'd5);
      cycle();
      cycle();
      chk("t1_valid", rsp_valid, 1'b1);
      chk("t1_id", rsp_id, 0);
      chk("t1_prod", rsp_prod, 120'd15);
      cycle();
      cycle();

      // T2: all-ones operands, full-width product
      setreq(2, '1, '1);
      cycle();
      cycle();
      big = (128'd1 << 120) - (128'd1 << 92) - (128'd1 << 28) + 128'd1;
      chk("t2_prod", rsp_prod, big);
      chk("t2_top_bit", rsp_prod[PW-1], 1'b1);
      cycle();
      cycle();

      // T3: all requesters continuously valid
      apply_reset();
      rsp_log.delete();
      mode = 1;
      for (int i = 0; i < NREQ; i++) newreq(i);
      for (int n = 0; n < 6; n++) cycle();
      chk("t3_grant_cnt", grant_cnt, 32'd6);
      mode = 0;
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      for (int n = 0; n < 3; n++) cycle();
      chk("t3_count", rsp_log.size(), 6);
      for (int k = 0; k < 6 && k < rsp_log.size(); k++) chk("t3_order", rsp_log[k], t3e[k]);

      // T4: backpressure with three queued requests
      rsp_log.delete();
      rsp_ready = 1'b0;
      newreq(0);
      newreq(1);
      newreq(2);
      cycle();
      cycle();
      held = rsp_prod;
      for (int n = 0; n < 4; n++) begin
         chk("t4_hold_prod", rsp_prod, held);
         chk("t4_hold_valid", rsp_valid, 1'b1);
         chk("t4_ready_zero", req_ready, '0);
         cycle();
      end
      rsp_ready = 1'b1;
      for (int n = 0; n < 6; n++) cycle();
      chk("t4_count", rsp_log.size(), 3);
      for (int k = 0; k < 3 && k < rsp_log.size(); k++) chk("t4_order", rsp_log[k], t4e[k]);

      // T5: pointer at 1, only requesters 0 and 3 valid
      newreq(0);
      cycle();
      cycle();
      cycle();
      newreq(0);
      newreq(3);
      drive();
      #1;
      chk("t5_first", req_ready, 4'b1000);
      cycle();
      drive();
      #1;
      chk("t5_second", req_ready, 4'b0001);
      cycle();
      for (int i = 0; i < NREQ; i++) newreq(i);
      drive();
      #1;
      chk("t5_ptr", req_ready, 4'b0010);
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      for (int n = 0; n < 3; n++) cycle();

      // T6: reset with both stages occupied
      rsp_ready = 1'b0;
      newreq(1);
      newreq(2);
      for (int n = 0; n < 3; n++) cycle();
      chk("t6_full", rsp_valid, 1'b1);
      apply_reset();
      rsp_ready = 1'b1;
      setreq(3, 28'd7, 92'd9);
      cycle();
      cycle();
      chk("t6_valid", rsp_valid, 1'b1);
      chk("t6_id", rsp_id, 3);
      chk("t6_prod", rsp_prod, 120'd63);
      cycle();
      cycle();

      // Randomized traffic with random consumer stalls
      mode = 2;
      for (int n = 0; n < 400; n++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 2) == 0) newreq(i);
         end
         cycle();
      end
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 4; n++) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
